// File: rtl/bp_be_fcsr_commit.sv
// bp_be_fcsr_commit
// Backend owner of the RISC-V fcsr (fflags + frm). Hands the dynamic rounding
// mode to the FP pipe. Carries each FP result's exception flags through a
// shadow pipeline of commit_depth_p stages. Flags are OR-ed stickily into
// fflags at the commit point. Also services CSR reads and writes of fflags
// (0x001), frm (0x002) and fcsr (0x003).
//
// Optional feature: define BP_BE_FCSR_COMMIT_BYPASS_EN so that reads of the
// fflags field also include the flags committing in the same cycle. Without
// the macro, reads come from the architectural registers only.

module bp_be_fcsr_commit #(
    parameter int commit_depth_p = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fflags_v_i,
    input  logic [4:0]  fflags_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        csr_w_v_i,
    input  logic [11:0] csr_addr_i,
    input  logic [63:0] csr_data_i,
    output logic [63:0] csr_data_o,
    output logic [2:0]  frm_o,
    output logic        frm_illegal_o,
    output logic        fs_dirty_o
);

    localparam logic [11:0] addr_fflags_lp = 12'h001;
    localparam logic [11:0] addr_frm_lp    = 12'h002;
    localparam logic [11:0] addr_fcsr_lp   = 12'h003;

    logic [commit_depth_p-1:0] shadow_v_r;
    logic [4:0]                shadow_flags_r [commit_depth_p];

    logic [4:0] fflags_r;
    logic [2:0] frm_r;
    logic       frm_illegal_r;
    logic       fs_dirty_r;

    logic       last_v_s;
    logic [4:0] last_flags_s;
    logic       commit_s;
    logic       wr_fflags_s;
    logic       wr_frm_s;
    logic [4:0] fflags_next_s;
    logic [2:0] frm_next_s;
    logic       dirty_next_s;
    logic [4:0] fflags_rd_s;
    logic [63:0] csr_data_s;

    assign last_v_s     = shadow_v_r[commit_depth_p-1];
    assign last_flags_s = shadow_flags_r[commit_depth_p-1];
    // The oldest entry retires only when the pipe advances and is not being killed.
    assign commit_s     = last_v_s & ~stall_i & ~flush_i;
    assign wr_fflags_s  = csr_w_v_i & ((csr_addr_i == addr_fflags_lp) | (csr_addr_i == addr_fcsr_lp));
    assign wr_frm_s     = csr_w_v_i & ((csr_addr_i == addr_frm_lp) | (csr_addr_i == addr_fcsr_lp));

    // Shadow shift register: flush empties it, stall freezes it, otherwise shift by one.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            shadow_v_r <= '0;
            for (int k = 0; k < commit_depth_p; k++) begin
                shadow_flags_r[k] <= 5'd0;
            end
        end else if (flush_i) begin
            shadow_v_r <= '0;
            for (int k = 0; k < commit_depth_p; k++) begin
                shadow_flags_r[k] <= 5'd0;
            end
        end else if (!stall_i) begin
            shadow_v_r[0]     <= fflags_v_i;
            shadow_flags_r[0] <= fflags_v_i ? fflags_i : 5'd0;
            for (int k = 1; k < commit_depth_p; k++) begin
                shadow_v_r[k]     <= shadow_v_r[k-1];
                shadow_flags_r[k] <= shadow_flags_r[k-1];
            end
        end else begin
            shadow_v_r <= shadow_v_r;
        end
    end

    // Next architectural fcsr state. A write to fflags discards a same-cycle commit,
    // because the committing FP op is older than the CSR instruction.
    // A frm-only write leaves the commit intact.
    always_comb begin
        fflags_next_s = fflags_r;
        frm_next_s    = frm_r;
        dirty_next_s  = 1'b0;
        if (wr_fflags_s) begin
            fflags_next_s = csr_data_i[4:0];
        end else if (commit_s) begin
            fflags_next_s = fflags_r | last_flags_s;
        end else begin
            fflags_next_s = fflags_r;
        end
        if (wr_frm_s) begin
            frm_next_s = (csr_addr_i == addr_fcsr_lp) ? csr_data_i[7:5] : csr_data_i[2:0];
        end else begin
            frm_next_s = frm_r;
        end
        if (wr_fflags_s || wr_frm_s) begin
            dirty_next_s = 1'b1;
        end else if (commit_s && ((last_flags_s & ~fflags_r) != 5'd0)) begin
            dirty_next_s = 1'b1;
        end else begin
            dirty_next_s = 1'b0;
        end
    end

    // Architectural fcsr registers and registered status outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fflags_r      <= 5'd0;
            frm_r         <= 3'd0;
            frm_illegal_r <= 1'b0;
            fs_dirty_r    <= 1'b0;
        end else begin
            fflags_r      <= fflags_next_s;
            frm_r         <= frm_next_s;
            frm_illegal_r <= (frm_next_s >= 3'd5);
            fs_dirty_r    <= dirty_next_s;
        end
    end

`ifdef BP_BE_FCSR_COMMIT_BYPASS_EN
    assign fflags_rd_s = fflags_r | (commit_s ? last_flags_s : 5'd0);
`else
    assign fflags_rd_s = fflags_r;
`endif

    // CSR read mux; unknown addresses read as zero.
    always_comb begin
        csr_data_s = 64'd0;
        case (csr_addr_i)
            addr_fflags_lp: csr_data_s = {59'd0, fflags_rd_s};
            addr_frm_lp:    csr_data_s = {61'd0, frm_r};
            addr_fcsr_lp:   csr_data_s = {56'd0, frm_r, fflags_rd_s};
            default:        csr_data_s = 64'd0;
        endcase
    end

    assign csr_data_o    = csr_data_s;
    assign frm_o         = frm_r;
    assign frm_illegal_o = frm_illegal_r;
    assign fs_dirty_o    = fs_dirty_r;

endmodule

// File: tb/tb_bp_be_fcsr_commit.sv
// Self-checking bench for bp_be_fcsr_commit: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_bp_be_fcsr_commit;

    localparam int DEPTH = 3;
`ifdef BP_BE_FCSR_COMMIT_BYPASS_EN
    localparam int LAT = DEPTH;
`else
    localparam int LAT = DEPTH + 1;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        fflags_v_i;
    logic [4:0]  fflags_i;
    logic        stall_i;
    logic        flush_i;
    logic        csr_w_v_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_data_i;
    logic [63:0] csr_data_o;
    logic [2:0]  frm_o;
    logic        frm_illegal_o;
    logic        fs_dirty_o;

    bp_be_fcsr_commit #(.commit_depth_p(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i), .fflags_v_i(fflags_v_i), .fflags_i(fflags_i),
        .stall_i(stall_i), .flush_i(flush_i), .csr_w_v_i(csr_w_v_i), .csr_addr_i(csr_addr_i),
        .csr_data_i(csr_data_i), .csr_data_o(csr_data_o), .frm_o(frm_o),
        .frm_illegal_o(frm_illegal_o), .fs_dirty_o(fs_dirty_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [4:0] f; int pos; } ent_t;
    ent_t       q[$];
    logic [4:0] m_fflags;
    logic [2:0] m_frm;
    logic       m_dirty;

    function automatic logic [63:0] model_read(input logic [11:0] a, input logic st, input logic fl);
        logic [4:0] ff;
        ff = m_fflags;
`ifdef BP_BE_FCSR_COMMIT_BYPASS_EN
        if (!st && !fl && q.size() > 0 && q[0].pos == DEPTH-1) ff = ff | q[0].f;
`endif
        if (a == 12'h001) return {59'd0, ff};
        if (a == 12'h002) return {61'd0, m_frm};
        if (a == 12'h003) return {56'd0, m_frm, ff};
        return 64'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_fflags = 5'd0;
        m_frm    = 3'd0;
        m_dirty  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [4:0] f, input logic st, input logic fl,
                              input logic w, input logic [11:0] a, input logic [63:0] d);
        logic commit, wff, wfm;
        logic [4:0] cf;
        ent_t e;
        commit = !fl && !st && q.size() > 0 && q[0].pos == DEPTH-1;
        cf  = commit ? q[0].f : 5'd0;
        wff = w && (a == 12'h001 || a == 12'h003);
        wfm = w && (a == 12'h002 || a == 12'h003);
        m_dirty = wff || wfm || (commit && !wff && ((cf & ~m_fflags) != 5'd0));
        if (wff) m_fflags = d[4:0];
        else     m_fflags = m_fflags | cf;
        if (wfm) m_frm = (a == 12'h003) ? d[7:5] : d[2:0];
        if (fl) begin
            q.delete();
        end else if (!st) begin
            if (commit) void'(q.pop_front());
            foreach (q[i]) q[i].pos = q[i].pos + 1;
            if (v) begin
                e.f = f;
                e.pos = 0;
                q.push_back(e);
            end
        end
    endtask

    // Sampled outputs from the most recent cycle.
    logic [63:0] s_rd;
    logic [2:0]  s_frm;
    logic        s_ill;
    logic        s_dirty;

    // Drive one cycle, compare against the model mid-cycle, then advance.
    task automatic do_cycle(input logic v, input logic [4:0] f, input logic st, input logic fl,
                            input logic w, input logic [11:0] a, input logic [63:0] d);
        fflags_v_i = v; fflags_i = f; stall_i = st; flush_i = fl;
        csr_w_v_i = w; csr_addr_i = a; csr_data_i = d;
        @(negedge clk);
        s_rd = csr_data_o; s_frm = frm_o; s_ill = frm_illegal_o; s_dirty = fs_dirty_o;
        check("model_rd", s_rd, model_read(a, st, fl));
        check("model_frm", {61'd0, s_frm}, {61'd0, m_frm});
        check("model_ill", {63'd0, s_ill}, {63'd0, (m_frm >= 3'd5)});
        check("model_dirty", {63'd0, s_dirty}, {63'd0, m_dirty});
        @(posedge clk);
        model_edge(v, f, st, fl, w, a, d);
        #1;
    endtask

    task automatic idle_read(input logic [11:0] a);
        do_cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, a, 64'd0);
    endtask

    task automatic clear_fflags();
        do_cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 12'h001, 64'd0);
        idle_read(12'h001);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [63:0] d;
        logic [63:0] exp_rd;
        logic [2:0]  exp_frm;
        logic        exp_ill;
        logic        exp_dirty;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int pulses;
        tbl[0]  = '{1'b0, 12'h003, 64'd0,                   64'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 12'h003, 64'hE5,                  64'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 12'h001, 64'd0,                   64'h05, 3'd7, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 12'h003, 64'd0,                   64'hE5, 3'd7, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 12'h002, 64'hFFFF_FFFF_FFFF_FFF9, 64'h07, 3'd7, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 12'h003, 64'd0,                   64'h25, 3'd1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 12'h004, 64'hFF,                  64'h00, 3'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 12'h003, 64'd0,                   64'h25, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 12'h001, 64'hFFFF_FFFF_FFFF_FFE0, 64'h05, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 12'h003, 64'd0,                   64'h20, 3'd1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 12'h003, 64'hA0,                  64'h20, 3'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 12'h002, 64'd0,                   64'h05, 3'd5, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 12'h003, 64'd0,                   64'hA0, 3'd5, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 12'h003, 64'd0,                   64'h00, 3'd0, 1'b0, 1'b1};

        reset_i = 1'b0; fflags_v_i = 1'b0; fflags_i = 5'd0; stall_i = 1'b0; flush_i = 1'b0;
        csr_w_v_i = 1'b0; csr_addr_i = 12'h003; csr_data_i = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd", csr_data_o, 64'd0);
        check("reset_frm", {61'd0, frm_o}, 64'd0);
        check("reset_ill", {63'd0, frm_illegal_o}, 64'd0);
        check("reset_dirty", {63'd0, fs_dirty_o}, 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            do_cycle(1'b0, 5'd0, 1'b0, 1'b0, tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_rd", i), s_rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_frm", i), {61'd0, s_frm}, {61'd0, tbl[i].exp_frm});
            check($sformatf("tbl%0d_ill", i), {63'd0, s_ill}, {63'd0, tbl[i].exp_ill});
            check($sformatf("tbl%0d_dirty", i), {63'd0, s_dirty}, {63'd0, tbl[i].exp_dirty});
        end

        // Latency: flags injected at c=0 appear at c=LAT; dirty pulses at DEPTH+1.
        for (int c = 0; c < 7; c++) begin
            do_cycle(c == 0, 5'h01, 1'b0, 1'b0, 1'b0, 12'h001, 64'd0);
            check($sformatf("lat_c%0d", c), s_rd, (c >= LAT) ? 64'h01 : 64'h00);
            check($sformatf("lat_dirty_c%0d", c), {63'd0, s_dirty}, {63'd0, (c == DEPTH+1)});
        end

        // Sticky OR: 0x01, 0x10, 0x01 -> 0x11, two dirty pulses.
        clear_fflags();
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            do_cycle(c < 3, (c == 1) ? 5'h10 : 5'h01, 1'b0, 1'b0, 1'b0, 12'h001, 64'd0);
            if (s_dirty) pulses++;
        end
        check("sticky_val", s_rd, 64'h11);
        check("sticky_pulses", pulses, 2);

        // Flush kills two in-flight entries; a later entry still lands.
        clear_fflags();
        for (int c = 0; c < 9; c++) begin
            do_cycle(c == 0 || c == 1 || c == 3, (c == 3) ? 5'h02 : 5'h04, 1'b0, c == 2,
                     1'b0, 12'h001, 64'd0);
            check($sformatf("flush_c%0d", c), s_rd, (c >= 3 + LAT) ? 64'h02 : 64'h00);
        end

        // Stall for four cycles delays the commit by four; valid inputs during stall are dropped.
        clear_fflags();
        for (int c = 0; c < 11; c++) begin
            do_cycle(c <= 4, (c == 0) ? 5'h08 : 5'h01, (c >= 1 && c <= 4), 1'b0,
                     1'b0, 12'h001, 64'd0);
            check($sformatf("stall_c%0d", c), s_rd, (c >= 4 + LAT) ? 64'h08 : 64'h00);
        end

        // Write to fflags in the commit cycle wins over the committing 0x10.
        clear_fflags();
        for (int c = 0; c < 6; c++) begin
            do_cycle(c == 0, 5'h10, 1'b0, 1'b0, c == DEPTH, 12'h001, 64'h03);
            if (c > DEPTH) check($sformatf("coll_c%0d", c), s_rd, 64'h03);
            if (c == DEPTH+1) check("coll_dirty", {63'd0, s_dirty}, 64'd1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [11:0] a;
            logic [2:0]  sel;
            sel = 3'($urandom_range(0, 4));
            a = (sel == 3'd0) ? 12'($urandom) : ((sel == 3'd4) ? 12'h003 : {9'd0, sel});
            do_cycle(1'($urandom), 5'($urandom), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, a,
                     {$urandom, $urandom});
        end

        // Asynchronous reset mid-cycle clears all state.
        do_cycle(1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 12'h003, 64'hFF);
        idle_read(12'h003);
        csr_addr_i = 12'h003;
        reset_i = 1'b0;
        #2;
        check("areset_rd", csr_data_o, 64'd0);
        check("areset_frm", {61'd0, frm_o}, 64'd0);
        check("areset_ill", {63'd0, frm_illegal_o}, 64'd0);
        check("areset_dirty", {63'd0, fs_dirty_o}, 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) idle_read(12'h003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_be_fcsr_commit.md
Name: bp_be_fcsr_commit

Overview:
- Architectural owner of the RISC-V fcsr (fflags + frm) in the backend; the consumer end of the FP pipe's rounding-mode/exception-flag interface.
- Supplies the dynamic rounding mode to the FP pipe and accepts its per-instruction exception flags.
- Carries the flags through a shadow pipeline to the commit point, then accumulates them stickily into fflags.
- Services CSR reads and writes of fflags (0x001), frm (0x002) and fcsr (0x003).

Parameters:
- commit_depth_p, 3: stages between FP pipe result and commit point; legal range 1 to 8.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- fflags_v_i  in  1  FP pipe result valid this cycle
- fflags_i  in  5  FP pipe eflags {NV,DZ,OF,UF,NX}
- stall_i  in  1  freeze shadow pipeline
- flush_i  in  1  kill all in-flight entries
- csr_w_v_i  in  1  CSR write strobe (commit-time)
- csr_addr_i  in  12  CSR address
- csr_data_i  in  64  CSR write data
- csr_data_o  out  64  CSR read data
- frm_o  out  3  dynamic rounding mode to FP pipe
- frm_illegal_o  out  1  frm_o is 5, 6 or 7
- fs_dirty_o  out  1  one-cycle pulse: fcsr state changed

Behaviour:
- Reset (reset_i low, asynchronous): fflags_r=0, frm_r=0 (RNE), all shadow valid bits 0, frm_o=0, frm_illegal_o=0, fs_dirty_o=0.
- Shadow pipeline: commit_depth_p registers of {v, flags[4:0]}.
  - Stage 0 loads {fflags_v_i, fflags_i}; stage k loads stage k-1.
  - Flags are zeroed whenever v=0.
- Stall: when stall_i=1, all stages hold and fflags_v_i is ignored; no commit occurs.
- Commit: when stall_i=0 and the last stage v=1, fflags_r <= fflags_r | last.flags at that edge.
- Latency: flags presented in cycle N are visible in csr_data_o in cycle N+commit_depth_p+1, given no stall or flush.
- Flush: flush_i=1 clears every stage valid, including the incoming entry and the entry committing that cycle. Flush has priority over commit and over stall.
- CSR write (csr_w_v_i=1):
  - 0x001: fflags_r <= data[4:0].
  - 0x002: frm_r <= data[2:0].
  - 0x003: frm_r <= data[7:5] and fflags_r <= data[4:0].
  - Any other address is ignored. Upper data bits are ignored.
  - Writes are honoured even during stall_i and flush_i.
- Write vs commit in the same cycle: the CSR write wins and the commit's flags are discarded (the committing entry is older than the CSR instruction).
- CSR read (combinational from registers): 0x001 returns {59'b0,fflags_r}; 0x002 returns {61'b0,frm_r}; 0x003 returns {56'b0,frm_r,fflags_r}; any other address returns 0.
- frm_o = frm_r, registered with no bypass; a write is seen by the pipe the next cycle.
- frm_illegal_o = (frm_r >= 5). The pipe raises illegal-instruction on dyn-rm ops; this block does not validate writes.
- fs_dirty_o pulses the cycle after either:
  - a CSR write to 0x001/0x002/0x003, or
  - a commit whose flags add a new bit to fflags_r.
  - Committing only already-set bits does not pulse.
- No internal full/empty condition exists: the pipeline is a fixed shift register, and one entry per cycle is accepted when not stalled.

Optional Feature:
- Macro: BP_BE_FCSR_COMMIT_BYPASS_EN.
- Enabled: the fflags field of csr_data_o (0x001/0x003) is fflags_r | committing flags in the same cycle (committing = last stage valid, not stalled, not flushed). The read therefore reflects the commit one cycle early, and latency becomes N+commit_depth_p.
- Disabled: reads are from registers only, as in Behaviour.

Test Plan:
- Reset then read: read 0x003 after reset -> 0. Write 0x003=0xE5 -> next cycle frm_o=7, frm_illegal_o=1, read 0x001=0x05, fs_dirty_o pulses once.
- Latency (depth 3): fflags_v_i=1, fflags_i=0x01 in cycle 10 -> read 0x001 is 0 through cycle 13 and 0x01 in cycle 14; fs_dirty_o high in cycle 14.
- Sticky OR: commit 0x01, then 0x10, then 0x01 -> fflags 0x11; fs_dirty_o pulses twice, not on the third commit.
- Flush: inject 0x04 in cycles 20 and 21, flush_i in cycle 22 -> fflags unchanged. Inject 0x02 in cycle 23 -> 0x02 visible in cycle 27.
- Stall: inject 0x08 in cycle 30, stall_i in cycles 31-34 -> 0x08 visible in cycle 38. fflags_v_i during the stall has no effect.
- Write/commit collision: entry 0x10 commits in the same cycle as a write 0x001=0x03 -> fflags=0x03.
